// File: rtl/uart_pack_decoder.sv
// Deframes PACK_NUM UART bytes into one checked command; 1-cycle latency from the final byte strobe.
// One-entry valid/ready hold buffer: a packet completing while the buffer is full and not accepted is dropped (overflow).
module uart_pack_decoder #(
  parameter int DATA_BIT    = 32,
  parameter int PACK_NUM    = (DATA_BIT/8)*2+3,
  parameter int TIMEOUT_CLK = 8000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [7:0]          data_i,
  input  logic                rx_done_tick_i,
  input  logic                pkt_ready_i,
  output logic                pkt_valid_o,
  output logic [DATA_BIT-1:0] out_pattern_o,
  output logic [DATA_BIT-1:0] freq_pattern_o,
  output logic [3:0]          channel_o,
  output logic                mode_o,
  output logic [7:0]          slow_period_o,
  output logic [7:0]          fast_period_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);

  localparam int CW = $clog2(PACK_NUM);
  localparam int TW = $clog2(TIMEOUT_CLK+1);
  localparam int SW = PACK_NUM*8;

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   tmo_q;
  logic [SW-9:0]   stage_q;
  logic [SW-1:0]   stage_nxt;
  logic [7:0]      ctrl;
  logic            tmo_hit, byte_ok, pkt_done, ctrl_ok, accept, load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_done_tick_i) state_d = RECV;
      RECV:    if (tmo_hit || pkt_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A byte landing in the same cycle as the timeout is discarded with the partial packet.
  always_comb begin
    busy_o    = (state_q == RECV);
    tmo_hit   = (state_q == RECV) && (tmo_q == TW'(TIMEOUT_CLK));
    byte_ok   = rx_done_tick_i && !tmo_hit;
    pkt_done  = byte_ok && (state_q == RECV) && (cnt_q == CW'(PACK_NUM-1));
    stage_nxt = {data_i, stage_q};
    ctrl      = stage_nxt[(PACK_NUM-3)*8 +: 8];
    ctrl_ok   = !ctrl[3] && (ctrl[1:0] == 2'b01);
    accept    = pkt_valid_o && pkt_ready_i;
    load      = pkt_done && ctrl_ok && (!pkt_valid_o || pkt_ready_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      tmo_q   <= '0;
      stage_q <= '0;
    end else begin
      if (tmo_hit)      cnt_q <= '0;
      else if (byte_ok) cnt_q <= pkt_done ? '0 : cnt_q + CW'(1);
      if (byte_ok) stage_q <= stage_nxt[SW-1:8];
      if (byte_ok || state_q == IDLE)      tmo_q <= '0;
      else if (tmo_q != TW'(TIMEOUT_CLK))  tmo_q <= tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_valid_o    <= 1'b0;
      out_pattern_o  <= '0;
      freq_pattern_o <= '0;
      channel_o      <= '0;
      mode_o         <= 1'b0;
      slow_period_o  <= '0;
      fast_period_o  <= '0;
      err_o          <= 1'b0;
      err_code_o     <= '0;
    end else begin
      err_o <= 1'b0;
      if (load) begin
        pkt_valid_o    <= 1'b1;
        out_pattern_o  <= stage_nxt[0 +: DATA_BIT];
        freq_pattern_o <= stage_nxt[DATA_BIT +: DATA_BIT];
        channel_o      <= ctrl[7:4];
        mode_o         <= ctrl[2];
        slow_period_o  <= stage_nxt[(PACK_NUM-2)*8 +: 8];
        fast_period_o  <= stage_nxt[(PACK_NUM-1)*8 +: 8];
      end else if (accept) begin
        pkt_valid_o <= 1'b0;
      end
      if (tmo_hit) begin
        err_o      <= 1'b1;
        err_code_o <= 2'd1;
      end else if (pkt_done && !ctrl_ok) begin
        err_o      <= 1'b1;
        err_code_o <= 2'd2;
      end else if (pkt_done && !load) begin
        err_o      <= 1'b1;
        err_code_o <= 2'd3;
      end
    end
  end

endmodule

// File: doc/uart_pack_decoder.md
# uart_pack_decoder

Byte-to-command deframer between the UART receiver and `diff_freq_serial_out`. It collects `PACK_NUM` bytes qualified by `rx_done_tick_i` into one packet and validates the control byte. It presents the decoded fields on a valid/ready output held in a one-entry buffer. Partial packets are discarded on an inter-byte timeout, so the downstream stage never sees a misaligned pattern.

## Interface
- `DATA_BIT`, 32: pattern width; must be a multiple of 8.
- `PACK_NUM`, (DATA_BIT/8)*2+3: bytes per packet.
- `TIMEOUT_CLK`, 8000: maximum idle clocks between bytes of one packet. This is about 2 byte times at 256000 baud and 100 MHz.

Ports:
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset; one clock, reset asynchronous and active-low.
- `data_i` in 8: received UART byte; valid only when `rx_done_tick_i`=1.
- `rx_done_tick_i` in 1: one-cycle byte strobe.
- `pkt_ready_i` in 1: downstream accepts the packet when high together with `pkt_valid_o`.
- `pkt_valid_o` out 1: a decoded packet is held.
- `out_pattern_o` out DATA_BIT: output pattern.
- `freq_pattern_o` out DATA_BIT: per-bit frequency select (1 = fast).
- `channel_o` out 4: target channel.
- `mode_o` out 1: 0 = one-shot, 1 = repeat.
- `slow_period_o` out 8: low-frequency bit period in clocks.
- `fast_period_o` out 8: high-frequency bit period in clocks.
- `busy_o` out 1: a partial packet is in progress.
- `err_o` out 1: one-cycle error pulse.
- `err_code_o` out 2: cause of the last error; holds its value until the next error.
  - 1 = timeout
  - 2 = bad control byte
  - 3 = overflow

## Operation
- Byte order within a packet:
  - Bytes 0..DATA_BIT/8-1 form `out_pattern`, least-significant byte first.
  - The next DATA_BIT/8 bytes form `freq_pattern`, least-significant byte first.
  - Byte PACK_NUM-3 is the control byte.
  - Byte PACK_NUM-2 is `slow_period`.
  - Byte PACK_NUM-1 is `fast_period`.
- Control byte fields: [7:4] channel, [3] reserved (must be 0), [2] mode, [1:0] command (must be 2'b01 = load).
- Byte counter width is clog2(PACK_NUM). Bytes are shifted into a staging register, and the counter increments on each `rx_done_tick_i`.
- FSM states:
  - IDLE: counter = 0. The first byte moves the FSM to RECV.
  - RECV: on the byte where counter = PACK_NUM-1, go to IDLE and evaluate the packet. If the timeout counter reaches TIMEOUT_CLK, go to IDLE, clear the counter, and signal a timeout error (code 1).
- Timeout counter: cleared on every byte, counts only in RECV, and saturates.
- Packet evaluation on completion:
  - If the control byte is invalid, drop the packet and signal error code 2.
  - Otherwise, if the holding buffer is empty, or it is accepted in the same cycle, load the buffer.
  - Otherwise drop the new packet, keep the old one, and signal error code 3.
- Holding buffer: `pkt_valid_o` sets when the buffer loads and clears when `pkt_valid_o & pkt_ready_i`. If an accept and a load occur in the same cycle, `pkt_valid_o` stays 1 and the new fields appear.
- Output fields stay stable while `pkt_valid_o`=1 and do not change on error.
- `busy_o` = (state == RECV).
- Reset, including mid-packet: the FSM returns to IDLE, the counters clear, and the staging register clears. All outputs go to 0, including `err_code_o`.

## Timing
- `pkt_valid_o` rises on the clock after the clock that samples the final `rx_done_tick_i` (1-cycle latency).
- Error pulses occur at the same cycle position:
  - Timeout: the cycle after the counter hits TIMEOUT_CLK.
  - Bad control byte and overflow: the cycle after the final byte.
- A byte that arrives in the same cycle the timeout fires is discarded together with the partial packet; the FSM still goes to IDLE.
- A byte arriving in IDLE after a timeout starts a new packet.
- `pkt_ready_i` may be held high permanently; each packet is then valid for exactly one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Send bytes 55 55 55 55 00 00 00 00 05 14 05 with `pkt_ready_i`=1.
  - Expect a one-cycle `pkt_valid_o` the clock after the 11th strobe.
  - Expect `out_pattern_o`=32'h55555555, `freq_pattern_o`=0, `channel_o`=0, `mode_o`=1, `slow_period_o`=8'h14, `fast_period_o`=8'h05, and no `err_o`.
- Send 5 bytes, idle for TIMEOUT_CLK+10 clocks, then send a full valid packet with control byte F1.
  - Expect one `err_o` pulse with code 1 and `busy_o` falling.
  - Expect the following packet to decode with `channel_o`=F and `mode_o`=0.
- Send a packet whose control byte is 0D (reserved bit set), then one with control byte 02 (command ≠ 01).
  - Expect two `err_o` pulses with code 2 and no `pkt_valid_o`.
- Hold `pkt_ready_i`=0 and send two valid packets.
  - Expect the first packet held, `err_o` with code 3 after the second packet, and the outputs still showing the first packet.
  - Raise `pkt_ready_i`; expect `pkt_valid_o` to drop after one cycle.
- Assert `pkt_ready_i` in exactly the cycle the second packet completes.
  - Expect no error, `pkt_valid_o` to stay high, and the second packet's fields to appear.
- Assert `rst_ni`=0 after 6 bytes, release it, then send a full packet.
  - Expect all outputs 0 during reset and `busy_o`=0 after reset.
  - Expect the full packet to decode correctly with no error.
